// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with a single-outstanding memory read,
//            a small PC/instruction buffer toward decode, and branch redirect.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int unsigned             wd_regs_p   = 32,
    parameter logic [wd_regs_p-1:0]    reset_pc_p  = '0,
    parameter int unsigned             buf_depth_p = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_br_taken,
    input  logic [wd_regs_p-1:0]  i_br_pc,
    output logic                  o_imem_req,
    output logic [wd_regs_p-1:0]  o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [wd_regs_p-1:0]  i_imem_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [wd_regs_p-1:0]  o_instr,
    output logic [wd_regs_p-1:0]  o_pc
);

    localparam int unsigned c_PTR_W = (buf_depth_p > 1) ? $clog2(buf_depth_p) : 1;
    localparam int unsigned c_CNT_W = $clog2(buf_depth_p) + 1;
    localparam logic [wd_regs_p-1:0] c_ALIGN_MASK = {{(wd_regs_p-2){1'b1}}, 2'b00};
    localparam logic [wd_regs_p-1:0] c_PC_STEP    = wd_regs_p'(4);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [wd_regs_p-1:0]   r_pc;
    logic [wd_regs_p-1:0]   r_fetch_pc;
    logic [wd_regs_p-1:0]   r_buf_pc    [buf_depth_p];
    logic [wd_regs_p-1:0]   r_buf_instr [buf_depth_p];
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   w_req;
    logic                   w_grant;
    logic                   w_push;
    logic                   w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A grant taken in a redirect cycle is still outstanding, so its response must be skipped.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = (r_count < c_CNT_W'(buf_depth_p));
                if (i_br_taken) begin
                    w_state_nxt = (w_req && i_imem_gnt) ? S_DISCARD : S_REQ;
                end else if (w_req && i_imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_br_taken) begin
                    w_state_nxt = i_imem_rvalid ? S_REQ : S_DISCARD;
                end else if (i_imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                if (i_imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Reset gates the request so it drops as soon as rst_n falls.
    assign o_imem_req  = w_req & rst_n;
    assign o_imem_addr = r_pc;
    assign w_grant     = o_imem_req & i_imem_gnt;
    assign w_push      = (r_state == S_WAIT) & i_imem_rvalid & ~i_br_taken;
    assign o_valid     = (r_count != '0);
    assign w_pop       = o_valid & i_ready;
    assign o_instr     = o_valid ? r_buf_instr[r_rptr] : '0;
    assign o_pc        = o_valid ? r_buf_pc[r_rptr]    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= reset_pc_p;
            r_fetch_pc <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
        end else if (i_br_taken) begin
            r_pc    <= i_br_pc & c_ALIGN_MASK;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_pc;
                r_pc       <= r_pc + c_PC_STEP;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]    <= r_fetch_pc;
            r_buf_instr[r_wptr] <= i_imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Randomized scoreboard bench for fetch_unit with a memory model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          D   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_br_taken = 1'b0;
    logic [31:0] i_br_pc = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    fetch_unit #(.wd_regs_p(W), .reset_pc_p(RPC), .buf_depth_p(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_br_taken   (i_br_taken),
        .i_br_pc      (i_br_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata (i_imem_rdata),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_instr      (o_instr),
        .o_pc         (o_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    ent_t        sbq[$];
    ent_t        mon_e;
    logic [31:0] m_pc = RPC;
    logic [31:0] m_fpc = '0;
    bit          m_squash = 0;
    bit          mem_pend = 0;
    int          mem_dly = 0;
    logic [31:0] mem_addr = '0;
    int          p_gnt = 100, p_rdy = 100, p_br = 0, max_dly = 1;
    int          dir_mode = 0;
    bit          mon_en = 0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: buffer occupancy and head contents against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (mon_en && rst_n) begin
            chk("o_valid", {63'd0, o_valid}, {63'd0, (sbq.size() != 0)});
            if (o_valid && i_ready && sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("o_pc", {32'd0, o_pc}, {32'd0, mon_e.pc});
                chk("o_instr", {32'd0, o_instr}, {32'd0, mon_e.ins});
            end
        end
    end

    task automatic cycle();
        bit          br, rv, gnt, rdy, grant, exp_req;
        logic [31:0] tgt;
        @(negedge clk);
        rv = 0;
        if (mem_pend && mem_dly == 1) rv = 1;
        else if (mem_pend) mem_dly--;
        gnt = ($urandom_range(0, 99) < p_gnt);
        rdy = ($urandom_range(0, 99) < p_rdy);
        br  = ($urandom_range(0, 99) < p_br);
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        case (dir_mode)
            1: if (o_imem_req) begin gnt = 1; br = 1; tgt = 32'h203; dir_mode = 0; end
            2: if (rv) begin br = 1; tgt = 32'h200; dir_mode = 0; end
            3: if (mem_pend && !rv && !m_squash) begin br = 1; tgt = 32'h100; dir_mode = 0; end
            4: begin br = 1; tgt = 32'hFFFF_FFF8; dir_mode = 0; end
            default: ;
        endcase
        i_imem_gnt    = gnt;
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? f(mem_addr) : $urandom;
        i_br_taken    = br;
        i_br_pc       = br ? tgt : $urandom;
        i_ready       = rdy;
        #1;
        exp_req = !mem_pend && (sbq.size() < D);
        chk("o_imem_req", {63'd0, o_imem_req}, {63'd0, exp_req});
        if (o_imem_req) chk("o_imem_addr", {32'd0, o_imem_addr}, {32'd0, m_pc});
        #2;
        grant = o_imem_req && gnt;
        if (rv) begin
            mem_pend = 0;
            if (!m_squash && !br) sbq.push_back(ent_t'{pc: m_fpc, ins: f(m_fpc)});
            m_squash = 0;
        end
        if (grant) begin
            mem_pend = 1;
            mem_dly  = $urandom_range(1, max_dly);
            mem_addr = o_imem_addr;
            m_fpc    = m_pc;
            m_pc     = m_pc + 32'd4;
            m_squash = 0;
        end
        if (br) begin
            m_pc = tgt & ~32'h3;
            sbq.delete();
            if (mem_pend) m_squash = 1;
        end
    endtask

    task automatic run(input int g, input int r, input int b, input int dl, input int n);
        p_gnt = g; p_rdy = r; p_br = b; max_dly = dl;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
        chk({tag, "_req"},   {63'd0, o_imem_req}, 64'd0);
        chk({tag, "_instr"}, {32'd0, o_instr}, 64'd0);
        chk({tag, "_pc"},    {32'd0, o_pc}, 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1;

        run(100, 100, 0, 1, 12);        // streaming fetch
        run(100, 0, 0, 1, 12);          // backpressure: buffer fills, requests stop
        run(100, 100, 0, 1, 10);        // drain and resume

        dir_mode = 3; run(100, 100, 0, 3, 20);
        chk("dir_wait_redirect", dir_mode, 0);
        dir_mode = 2; run(100, 100, 0, 1, 20);
        chk("dir_rvalid_redirect", dir_mode, 0);
        dir_mode = 1; run(100, 100, 0, 2, 20);
        chk("dir_grant_redirect", dir_mode, 0);
        dir_mode = 4; run(100, 100, 0, 1, 15);
        chk("dir_wrap_redirect", dir_mode, 0);

        run(70, 70, 8, 3, 3000);

        // Asynchronous reset while a read is outstanding and data is buffered.
        p_rdy = 0; max_dly = 3; p_br = 0; p_gnt = 100;
        for (int k = 0; k < 200 && !(sbq.size() >= 1 && mem_pend); k++) cycle();
        @(negedge clk);
        i_imem_gnt = 0; i_imem_rvalid = 0; i_br_taken = 0; i_ready = 0;
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        i_imem_rvalid = 1'b0;
        sbq.delete();
        m_pc = RPC; mem_pend = 0; m_squash = 0;
        #1;
        rst_n = 1'b1;

        run(100, 100, 0, 1, 10);
        run(70, 70, 8, 3, 800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
